keyboard_mode_arbiter: RTL and testbench
========================================

Name: keyboard_mode_arbiter

Overview:
- Top-level mode arbiter for the electronic keyboard.
- Selects among free-play, auto-play and learn sub-block outputs and drives the single note/LED/digit/octave path to the audio and display blocks.
- Generalises the earlier controller:
  - parametrised widths;
  - free mode actually implemented (key encoder);
  - debounced mode switching;
  - a muted guard interval between modes;
  - a restart pulse to the newly selected sub-block.

Parameters:
- NOTE_W, 4, width of note codes (0 = rest, 1..7 = do..si).
- LED_W, 7, number of keys/LEDs.
- NUM_W, 4, width of the digit/score display value.
- OCT_W, 2, octave select width.
- STABLE_CYCLES, 2000000, consecutive cycles a new mode request must be held before acceptance (>=1).
- MUTE_CYCLES, 5000000, guard interval with forced rest between modes (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- mode  in  3  one-hot request: 100 free, 010 auto, 001 learn.
- keys  in  LED_W  piano key switches, bit0 = do.
- octave  in  OCT_W  user octave switches.
- note_auto, note_learn  in  NOTE_W each  sub-block notes.
- led_auto, led_learn  in  LED_W each  sub-block LED patterns.
- num_auto, num_learn  in  NUM_W each  sub-block display values.
- octave_auto  in  OCT_W  auto-play octave.
- note_out  out  NOTE_W  note to buzzer.
- led_out  out  LED_W  LED drive.
- num_out  out  NUM_W  display value.
- octave_out  out  OCT_W  octave to buzzer.
- active_mode  out  3  one-hot mode currently driving outputs; 000 when none.
- restart_auto, restart_learn  out  1 each  one-cycle restart pulses to sub-blocks.
- switching  out  1  high while in MUTE.

Behaviour:
- Reset (async, immediate):
  - all outputs 0;
  - state IDLE;
  - target mode 000;
  - all counters 0.
- Request filter, runs in every state:
  - A request is valid only if mode is exactly one-hot. Invalid values (000, 011, 111, ...) clear the stability counter and are ignored.
  - The counter increments while mode equals the previous cycle's mode, and restarts at 1 when mode changes.
  - A valid request is accepted when the counter reaches STABLE_CYCLES and the request differs from the target. Acceptance is a one-cycle event; the counter saturates so the request is not re-accepted.
- States:
  - IDLE: outputs 0. On accept: target <= request, go to MUTE.
  - MUTE:
    - switching=1, note_out=0, led_out=0;
    - num_out and octave_out hold their last values;
    - active_mode=000.
    - The mute counter runs 0..MUTE_CYCLES-1.
    - An accept during MUTE updates the target and restarts the mute counter at 0.
    - On the terminal count: go to ACTIVE; active_mode <= target; pulse the restart output for the target (auto or learn) for exactly one cycle (none for free).
  - ACTIVE: outputs follow the target source, registered (1-cycle latency from inputs).
    - Free:
      - note_out = index+1 of the lowest set key bit, 0 if no key is set;
      - led_out = keys;
      - num_out = note_out zero-extended/truncated to NUM_W;
      - octave_out = octave.
    - Auto: note_auto, led_auto, num_auto, octave_auto.
    - Learn: note_learn, led_learn, num_learn, octave.
    - On accept: go to MUTE with the new target.
- Re-selecting the already-active mode is never an accept, so there is no mute and no restart.
- Reset mid-MUTE or mid-ACTIVE returns to IDLE. After reset release, a held valid mode must again be stable STABLE_CYCLES cycles before acceptance.
- Counter widths are sized by $clog2 of each parameter (+1); counters must not wrap.

Test Plan:
Bench uses STABLE_CYCLES=4, MUTE_CYCLES=8.
1. Reset, then mode=100 held.
   - Accept on the 4th cycle.
   - switching high 8 cycles, note_out=0.
   - Then active_mode=100; no restart pulse.
   - keys=0010100 -> note_out=3, led_out=0010100, num_out=3, one cycle after keys change.
2. From free, mode=010 held.
   - MUTE 8 cycles.
   - restart_auto pulses exactly one cycle.
   - note_auto=5, octave_auto=2 appear on note_out/octave_out one cycle later.
3. mode toggles 010/001 every 2 cycles, then 011 for 10 cycles.
   - No accept; active_mode unchanged; no switching.
4. In MUTE toward learn, mode=100 held 4 cycles at mute count 5.
   - Mute restarts.
   - Ends 8 cycles after the second accept with active_mode=100 and no restart_learn.
5. Assert reset asynchronously mid-ACTIVE (between clock edges).
   - All outputs 0 immediately.
   - With mode=001 still held, no accept for 4 cycles after release, then the normal MUTE sequence and a restart_learn pulse.
6. In learn mode, with keys=0 and note_learn=7, led_learn=1000000, num_learn=9.
   - Outputs 7/1000000/9, octave_out = octave switches.
   - Re-requesting 001 causes no restart.

Source files
------------

// File: rtl/keyboard_mode_arbiter.sv
// -----------------------------------------------------------------------------
// keyboard_mode_arbiter
//
// Top-level mode arbiter for the electronic keyboard. It picks one of the
// free-play (key encoder inside this block), auto-play or learn sub-blocks and
// drives the single note/LED/digit/octave path towards the audio and display
// blocks.
//
// Mode requests are debounced: a one-hot request must be held unchanged for
// STABLE_CYCLES cycles before it is accepted. Each accepted switch passes
// through a muted guard interval of MUTE_CYCLES cycles. At the end of that
// interval the newly selected sub-block gets a one-cycle restart pulse.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   mode[2:0]               one-hot request: 100 free, 010 auto, 001 learn
//   keys[LED_W]             piano key switches, bit0 = do
//   octave[OCT_W]           user octave switches
//   note/led/num_auto       auto-play sub-block outputs, plus octave_auto
//   note/led/num_learn      learn sub-block outputs
//   note_out, led_out,
//   num_out, octave_out     registered output path
//   active_mode[2:0]        one-hot mode currently driving outputs, 000 if none
//   restart_auto/_learn     one-cycle restart pulses to the sub-blocks
//   switching               high while in the muted guard interval
// -----------------------------------------------------------------------------
module keyboard_mode_arbiter #(
  parameter int NOTE_W        = 4,
  parameter int LED_W         = 7,
  parameter int NUM_W         = 4,
  parameter int OCT_W         = 2,
  parameter int STABLE_CYCLES = 2000000,
  parameter int MUTE_CYCLES   = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mode,
  input  logic [LED_W-1:0]  keys,
  input  logic [OCT_W-1:0]  octave,
  input  logic [NOTE_W-1:0] note_auto,
  input  logic [NOTE_W-1:0] note_learn,
  input  logic [LED_W-1:0]  led_auto,
  input  logic [LED_W-1:0]  led_learn,
  input  logic [NUM_W-1:0]  num_auto,
  input  logic [NUM_W-1:0]  num_learn,
  input  logic [OCT_W-1:0]  octave_auto,
  output logic [NOTE_W-1:0] note_out,
  output logic [LED_W-1:0]  led_out,
  output logic [NUM_W-1:0]  num_out,
  output logic [OCT_W-1:0]  octave_out,
  output logic [2:0]        active_mode,
  output logic              restart_auto,
  output logic              restart_learn,
  output logic              switching
);

  localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
  localparam int MUTE_W = $clog2(MUTE_CYCLES) + 1;
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [MUTE_W-1:0] MUTE_LAST = MUTE_W'(MUTE_CYCLES - 1);
  // Number of note bits that survive into the digit display value.
  localparam int NUM_CP = (NUM_W < NOTE_W) ? NUM_W : NOTE_W;

  localparam logic [2:0] M_FREE  = 3'b100;
  localparam logic [2:0] M_AUTO  = 3'b010;
  localparam logic [2:0] M_LEARN = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUTE   = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        prev_mode_q, prev_mode_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic [MUTE_W-1:0] mute_cnt_q, mute_cnt_d;
  logic [2:0]        target_q, target_d;

  logic [NOTE_W-1:0] note_out_q, note_out_d;
  logic [LED_W-1:0]  led_out_q, led_out_d;
  logic [NUM_W-1:0]  num_out_q, num_out_d;
  logic [OCT_W-1:0]  octave_out_q, octave_out_d;
  logic [2:0]        active_mode_q, active_mode_d;
  logic              restart_auto_q, restart_auto_d;
  logic              restart_learn_q, restart_learn_d;

  logic              req_valid;
  logic              accept;
  logic [NOTE_W-1:0] free_note;
  logic [NUM_W-1:0]  free_num;

  // ---------------------------------------------------------------------------
  // Request filter
  // ---------------------------------------------------------------------------
  assign req_valid = (mode == M_FREE) || (mode == M_AUTO) || (mode == M_LEARN);
  assign prev_mode_d = mode;

  always_comb begin
    stab_cnt_d = stab_cnt_q;
    if (!req_valid) begin
      stab_cnt_d = '0;
    end else if (mode != prev_mode_q) begin
      stab_cnt_d = STAB_W'(1);
    end else if (stab_cnt_q != STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + STAB_W'(1);
    end
  end

  // Accept fires only on the cycle the count first lands on STABLE_CYCLES.
  // A freshly changed request counts as "first landing" too, which keeps
  // STABLE_CYCLES == 1 working even when the previous count was saturated.
  assign accept = req_valid && (stab_cnt_d == STAB_MAX) &&
                  ((stab_cnt_q != STAB_MAX) || (mode != prev_mode_q)) &&
                  (mode != target_q);

  // ---------------------------------------------------------------------------
  // Free-play key encoder: lowest set key wins, note = index + 1.
  // ---------------------------------------------------------------------------
  always_comb begin
    free_note = '0;
    for (int i = LED_W - 1; i >= 0; i--) begin
      if (keys[i]) free_note = NOTE_W'(i + 1);
    end
  end

  always_comb begin
    free_num = '0;
    for (int i = 0; i < NUM_CP; i++) begin
      free_num[i] = free_note[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Mode FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    mute_cnt_d = mute_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_MUTE;
          target_d   = mode;
          mute_cnt_d = '0;
        end
      end
      S_MUTE: begin
        if (accept) begin
          // A newer request extends the guard interval from scratch.
          target_d   = mode;
          mute_cnt_d = '0;
        end else if (mute_cnt_q == MUTE_LAST) begin
          state_d    = S_ACTIVE;
          mute_cnt_d = '0;
        end else begin
          mute_cnt_d = mute_cnt_q + MUTE_W'(1);
        end
      end
      S_ACTIVE: begin
        if (accept) begin
          state_d    = S_MUTE;
          target_d   = mode;
          mute_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        target_d   = '0;
        mute_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output path, registered from the state being entered so every output has
  // exactly one cycle of latency from its source.
  // ---------------------------------------------------------------------------
  always_comb begin
    note_out_d      = '0;
    led_out_d       = '0;
    num_out_d       = num_out_q;
    octave_out_d    = octave_out_q;
    active_mode_d   = '0;
    restart_auto_d  = 1'b0;
    restart_learn_d = 1'b0;
    case (state_d)
      S_MUTE: begin
        // Forced rest; digit and octave keep showing their last values.
      end
      S_ACTIVE: begin
        active_mode_d = target_d;
        case (target_d)
          M_FREE: begin
            note_out_d   = free_note;
            led_out_d    = keys;
            num_out_d    = free_num;
            octave_out_d = octave;
          end
          M_AUTO: begin
            note_out_d   = note_auto;
            led_out_d    = led_auto;
            num_out_d    = num_auto;
            octave_out_d = octave_auto;
          end
          M_LEARN: begin
            note_out_d   = note_learn;
            led_out_d    = led_learn;
            num_out_d    = num_learn;
            octave_out_d = octave;
          end
          default: begin
            num_out_d    = '0;
            octave_out_d = '0;
          end
        endcase
        if (state_q == S_MUTE) begin
          restart_auto_d  = (target_d == M_AUTO);
          restart_learn_d = (target_d == M_LEARN);
        end
      end
      default: begin
        num_out_d    = '0;
        octave_out_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      prev_mode_q     <= '0;
      stab_cnt_q      <= '0;
      mute_cnt_q      <= '0;
      target_q        <= '0;
      note_out_q      <= '0;
      led_out_q       <= '0;
      num_out_q       <= '0;
      octave_out_q    <= '0;
      active_mode_q   <= '0;
      restart_auto_q  <= 1'b0;
      restart_learn_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      prev_mode_q     <= prev_mode_d;
      stab_cnt_q      <= stab_cnt_d;
      mute_cnt_q      <= mute_cnt_d;
      target_q        <= target_d;
      note_out_q      <= note_out_d;
      led_out_q       <= led_out_d;
      num_out_q       <= num_out_d;
      octave_out_q    <= octave_out_d;
      active_mode_q   <= active_mode_d;
      restart_auto_q  <= restart_auto_d;
      restart_learn_q <= restart_learn_d;
    end
  end

  assign note_out      = note_out_q;
  assign led_out       = led_out_q;
  assign num_out       = num_out_q;
  assign octave_out    = octave_out_q;
  assign active_mode   = active_mode_q;
  assign restart_auto  = restart_auto_q;
  assign restart_learn = restart_learn_q;
  assign switching     = (state_q == S_MUTE);

endmodule

// File: tb/tb_keyboard_mode_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keyboard_mode_arbiter
//
// Directed bench for keyboard_mode_arbiter with STABLE_CYCLES=4 and
// MUTE_CYCLES=8. Inputs change on falling edges; outputs are sampled on
// falling edges, half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_keyboard_mode_arbiter;

  localparam int NOTE_W = 4;
  localparam int LED_W  = 7;
  localparam int NUM_W  = 4;
  localparam int OCT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        mode;
  logic [LED_W-1:0]  keys;
  logic [OCT_W-1:0]  octave;
  logic [NOTE_W-1:0] note_auto, note_learn;
  logic [LED_W-1:0]  led_auto, led_learn;
  logic [NUM_W-1:0]  num_auto, num_learn;
  logic [OCT_W-1:0]  octave_auto;
  logic [NOTE_W-1:0] note_out;
  logic [LED_W-1:0]  led_out;
  logic [NUM_W-1:0]  num_out;
  logic [OCT_W-1:0]  octave_out;
  logic [2:0]        active_mode;
  logic              restart_auto, restart_learn, switching;

  int n_chk  = 0;
  int n_fail = 0;

  keyboard_mode_arbiter #(
    .NOTE_W(NOTE_W), .LED_W(LED_W), .NUM_W(NUM_W), .OCT_W(OCT_W),
    .STABLE_CYCLES(4), .MUTE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .keys(keys), .octave(octave),
    .note_auto(note_auto), .note_learn(note_learn),
    .led_auto(led_auto), .led_learn(led_learn),
    .num_auto(num_auto), .num_learn(num_learn),
    .octave_auto(octave_auto),
    .note_out(note_out), .led_out(led_out), .num_out(num_out),
    .octave_out(octave_out), .active_mode(active_mode),
    .restart_auto(restart_auto), .restart_learn(restart_learn),
    .switching(switching)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " note"}, 32'(note_out), 32'd0);
    chk({tag, " led"}, 32'(led_out), 32'd0);
    chk({tag, " num"}, 32'(num_out), 32'd0);
    chk({tag, " oct"}, 32'(octave_out), 32'd0);
    chk({tag, " active"}, 32'(active_mode), 32'd0);
    chk({tag, " ra"}, 32'(restart_auto), 32'd0);
    chk({tag, " rl"}, 32'(restart_learn), 32'd0);
    chk({tag, " sw"}, 32'(switching), 32'd0);
  endtask

  // Called right after a new request is driven on a falling edge: accept on
  // the 4th rising edge, 8 muted cycles, then activation with restart pulse.
  task automatic run_switch(input string tag, input logic [2:0] exp_mode,
                            input logic [31:0] hold_num, input logic [31:0] hold_oct,
                            input logic exp_ra, input logic exp_rl);
    repeat (3) begin
      tick();
      chk({tag, " pre sw"}, 32'(switching), 32'd0);
    end
    tick();
    chk({tag, " mute sw"}, 32'(switching), 32'd1);
    chk({tag, " mute note"}, 32'(note_out), 32'd0);
    chk({tag, " mute led"}, 32'(led_out), 32'd0);
    chk({tag, " mute active"}, 32'(active_mode), 32'd0);
    chk({tag, " mute num"}, 32'(num_out), hold_num);
    chk({tag, " mute oct"}, 32'(octave_out), hold_oct);
    chk({tag, " mute ra"}, 32'(restart_auto), 32'd0);
    chk({tag, " mute rl"}, 32'(restart_learn), 32'd0);
    repeat (7) begin
      tick();
      chk({tag, " mute sw"}, 32'(switching), 32'd1);
      chk({tag, " mute active"}, 32'(active_mode), 32'd0);
    end
    tick();
    chk({tag, " end sw"}, 32'(switching), 32'd0);
    chk({tag, " active"}, 32'(active_mode), 32'(exp_mode));
    chk({tag, " ra pulse"}, 32'(restart_auto), 32'(exp_ra));
    chk({tag, " rl pulse"}, 32'(restart_learn), 32'(exp_rl));
    tick();
    chk({tag, " ra after"}, 32'(restart_auto), 32'd0);
    chk({tag, " rl after"}, 32'(restart_learn), 32'd0);
  endtask

  initial begin
    reset = 1'b1; mode = 3'b000; keys = '0; octave = '0;
    note_auto = '0; note_learn = '0; led_auto = '0; led_learn = '0;
    num_auto = '0; num_learn = '0; octave_auto = '0;
    tick(); tick();
    chk_all_zero("reset");

    // 1: free mode from IDLE
    reset = 1'b0; mode = 3'b100;
    run_switch("t1", 3'b100, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1 no-key note", 32'(note_out), 32'd0);
    keys = 7'b0010100; octave = 2'd1;
    #1 chk("t1 latency", 32'(note_out), 32'd0);
    tick();
    chk("t1 note", 32'(note_out), 32'd3);
    chk("t1 led", 32'(led_out), 32'h14);
    chk("t1 num", 32'(num_out), 32'd3);
    chk("t1 oct", 32'(octave_out), 32'd1);
    keys = 7'b1000000;
    tick();
    chk("t1 top key note", 32'(note_out), 32'd7);
    chk("t1 top key num", 32'(num_out), 32'd7);
    keys = 7'b0010100;
    tick();
    chk("t1 restore note", 32'(note_out), 32'd3);

    // 2: free -> auto
    note_auto = 4'd5; led_auto = 7'h2A; num_auto = 4'd6; octave_auto = 2'd2;
    mode = 3'b010;
    run_switch("t2", 3'b010, 32'd3, 32'd1, 1'b1, 1'b0);
    chk("t2 note", 32'(note_out), 32'd5);
    chk("t2 oct", 32'(octave_out), 32'd2);
    chk("t2 led", 32'(led_out), 32'h2A);
    chk("t2 num", 32'(num_out), 32'd6);
    note_auto = 4'd2;
    #1 chk("t2 latency", 32'(note_out), 32'd5);
    tick();
    chk("t2 follow", 32'(note_out), 32'd2);

    // 3: unstable and invalid requests
    for (int r = 0; r < 3; r++) begin
      mode = 3'b001;
      repeat (2) begin
        tick();
        chk("t3 toggle sw", 32'(switching), 32'd0);
        chk("t3 toggle active", 32'(active_mode), 32'b010);
      end
      mode = 3'b010;
      repeat (2) begin
        tick();
        chk("t3 toggle sw", 32'(switching), 32'd0);
        chk("t3 toggle active", 32'(active_mode), 32'b010);
      end
    end
    mode = 3'b011;
    repeat (10) begin
      tick();
      chk("t3 invalid sw", 32'(switching), 32'd0);
      chk("t3 invalid active", 32'(active_mode), 32'b010);
    end
    mode = 3'b010;
    repeat (6) begin
      tick();
      chk("t3 same sw", 32'(switching), 32'd0);
      chk("t3 same ra", 32'(restart_auto), 32'd0);
    end

    // 4: request for free arrives mid-mute towards learn
    mode = 3'b001;
    repeat (3) begin
      tick();
      chk("t4 pre sw", 32'(switching), 32'd0);
    end
    tick();
    chk("t4 mute sw", 32'(switching), 32'd1);
    chk("t4 mute num", 32'(num_out), 32'd6);
    chk("t4 mute oct", 32'(octave_out), 32'd2);
    tick(); tick();
    mode = 3'b100;
    repeat (4) begin
      tick();
      chk("t4 hold sw", 32'(switching), 32'd1);
    end
    repeat (7) begin
      tick();
      chk("t4 extended sw", 32'(switching), 32'd1);
      chk("t4 extended rl", 32'(restart_learn), 32'd0);
    end
    tick();
    chk("t4 end sw", 32'(switching), 32'd0);
    chk("t4 active", 32'(active_mode), 32'b100);
    chk("t4 rl", 32'(restart_learn), 32'd0);
    chk("t4 ra", 32'(restart_auto), 32'd0);
    chk("t4 note", 32'(note_out), 32'd3);
    chk("t4 oct", 32'(octave_out), 32'd1);

    // 5: async reset mid-ACTIVE
    tick();
    mode = 3'b001;
    tick(); tick();
    chk("t5 pre active", 32'(active_mode), 32'b100);
    chk("t5 pre note", 32'(note_out), 32'd3);
    #2 reset = 1'b1;
    #1 chk_all_zero("t5 async");
    keys = '0; note_learn = 4'd7; led_learn = 7'b1000000; num_learn = 4'd9; octave = 2'd3;
    tick(); tick();
    chk("t5 held active", 32'(active_mode), 32'd0);
    reset = 1'b0;
    run_switch("t5", 3'b001, 32'd0, 32'd0, 1'b0, 1'b1);

    // 6: learn outputs and re-request
    chk("t6 note", 32'(note_out), 32'd7);
    chk("t6 led", 32'(led_out), 32'h40);
    chk("t6 num", 32'(num_out), 32'd9);
    chk("t6 oct", 32'(octave_out), 32'd3);
    octave = 2'd2;
    tick();
    chk("t6 oct follow", 32'(octave_out), 32'd2);
    mode = 3'b000;
    repeat (2) begin
      tick();
      chk("t6 gap sw", 32'(switching), 32'd0);
    end
    mode = 3'b001;
    repeat (6) begin
      tick();
      chk("t6 rereq sw", 32'(switching), 32'd0);
      chk("t6 rereq rl", 32'(restart_learn), 32'd0);
      chk("t6 rereq active", 32'(active_mode), 32'b001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
